// File: rtl/decode_unit_if.sv
// decode_unit_if: bundles the IF/ID, register-file write, forwarding and
// decode-control signals of decode_unit. The performance counter outputs
// only exist when DECODE_PERF_EN is defined.
interface decode_unit_if #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int FWD_SRC = 3
);
  localparam int AW = $clog2(REG_NUM);
  localparam int SW = $clog2(FWD_SRC + 1);

  logic [31:0]             instr_f;
  logic [31:0]             pc_f;
  logic                    stall;
  logic                    flush;
  logic                    rf_we;
  logic [AW-1:0]           rf_wa;
  logic [DATA_W-1:0]       rf_wd;
  logic [FWD_SRC*DATA_W-1:0] fwd_data;
  logic [SW-1:0]           fwd_sel1;
  logic [SW-1:0]           fwd_sel2;
  logic                    ext_op;
  logic [2:0]              cmp_op;
  logic [1:0]              npc_op;

  logic [31:0]             instr_d;
  logic [31:0]             pc_d;
  logic [DATA_W-1:0]       rd1;
  logic [DATA_W-1:0]       rd2;
  logic [DATA_W-1:0]       imm32;
  logic [31:0]             next_pc;
  logic                    br_taken;
`ifdef DECODE_PERF_EN
  logic [15:0]             stall_cnt;
  logic [15:0]             br_cnt;
`endif

  // Pipeline / control side: drives fetch, writeback and control inputs.
  modport master (
    output instr_f, pc_f, stall, flush, rf_we, rf_wa, rf_wd,
           fwd_data, fwd_sel1, fwd_sel2, ext_op, cmp_op, npc_op,
    input  instr_d, pc_d, rd1, rd2, imm32, next_pc, br_taken
`ifdef DECODE_PERF_EN
    , input stall_cnt, br_cnt
`endif
  );

  // Decode stage side.
  modport slave (
    input  instr_f, pc_f, stall, flush, rf_we, rf_wa, rf_wd,
           fwd_data, fwd_sel1, fwd_sel2, ext_op, cmp_op, npc_op,
    output instr_d, pc_d, rd1, rd2, imm32, next_pc, br_taken
`ifdef DECODE_PERF_EN
    , output stall_cnt, br_cnt
`endif
  );
endinterface

// File: rtl/decode_unit.sv
// decode_unit: IF/ID pipeline register, register file with write-through
// bypass, operand forwarding muxes, immediate extension, branch compare and
// next-PC selection. Defining DECODE_PERF_EN adds saturating stall/branch
// counters (stall_cnt, br_cnt) to the interface.
module decode_unit #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int FWD_SRC = 3
) (
  input logic          clk,
  input logic          reset,
  decode_unit_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic [31:0]       ifid_pc_q, ifid_pc_d;
  logic [DATA_W-1:0] rf_q [REG_NUM];
  logic [AW-1:0]     rs_a, rt_a;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] rd1_v, rd2_v;
  logic [DATA_W-1:0] imm_v;
  logic              cmp_true;
  logic              br_taken_v;
  logic [31:0]       br_off, br_tgt, pc_f_p4;
  logic [31:0]       next_pc_v;

  // IF/ID next state: stall holds everything and wins over flush.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (!bus.stall) begin
      ifid_pc_d    = bus.pc_f;
      ifid_instr_d = bus.flush ? 32'd0 : bus.instr_f;
    end
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= PC_RESET;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  // Register file storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
    end else if (bus.rf_we && (bus.rf_wa != '0)) begin
      rf_q[bus.rf_wa] <= bus.rf_wd;
    end
  end

  // Register specifiers, resized to the register-file address width.
  assign rs_a = AW'(ifid_instr_q[25:21]);
  assign rt_a = AW'(ifid_instr_q[20:16]);

  // Combinational reads with write-through bypass of the same-cycle write.
  always_comb begin
    rf_rd1 = rf_q[rs_a];
    rf_rd2 = rf_q[rt_a];
    if (rs_a == '0) rf_rd1 = '0;
    else if (bus.rf_we && (bus.rf_wa == rs_a)) rf_rd1 = bus.rf_wd;
    if (rt_a == '0) rf_rd2 = '0;
    else if (bus.rf_we && (bus.rf_wa == rt_a)) rf_rd2 = bus.rf_wd;
  end

  // Forwarding muxes: select k+1 picks source k; 0 or out-of-range keeps RF.
  always_comb begin
    rd1_v = rf_rd1;
    rd2_v = rf_rd2;
    for (int k = 0; k < FWD_SRC; k++) begin
      if (int'(bus.fwd_sel1) == k + 1) rd1_v = bus.fwd_data[k*DATA_W +: DATA_W];
      if (int'(bus.fwd_sel2) == k + 1) rd2_v = bus.fwd_data[k*DATA_W +: DATA_W];
    end
  end

  assign imm_v = bus.ext_op ? {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]}
                            : {{(DATA_W-16){1'b0}}, ifid_instr_q[15:0]};

  // Signed branch condition; only meaningful for the branch next-PC mode.
  always_comb begin
    cmp_true = 1'b0;
    case (bus.cmp_op)
      3'd0: cmp_true = (rd1_v == rd2_v);
      3'd1: cmp_true = (rd1_v != rd2_v);
      3'd2: cmp_true = ($signed(rd1_v) <= 0);
      3'd3: cmp_true = ($signed(rd1_v) >  0);
      3'd4: cmp_true = ($signed(rd1_v) <  0);
      3'd5: cmp_true = ($signed(rd1_v) >= 0);
      default: cmp_true = 1'b0;
    endcase
  end

  assign br_taken_v = (bus.npc_op == 2'd1) && cmp_true;
  assign br_off     = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
  assign br_tgt     = ifid_pc_q + 32'd4 + br_off;
  assign pc_f_p4    = bus.pc_f + 32'd4;

  // Next-PC select; all additions wrap modulo 2^32.
  always_comb begin
    next_pc_v = pc_f_p4;
    case (bus.npc_op)
      2'd0: next_pc_v = pc_f_p4;
      2'd1: next_pc_v = br_taken_v ? br_tgt : pc_f_p4;
      2'd2: next_pc_v = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
      default: next_pc_v = rd1_v[31:0];
    endcase
  end

  assign bus.instr_d  = ifid_instr_q;
  assign bus.pc_d     = ifid_pc_q;
  assign bus.rd1      = rd1_v;
  assign bus.rd2      = rd2_v;
  assign bus.imm32    = imm_v;
  assign bus.next_pc  = next_pc_v;
  assign bus.br_taken = br_taken_v;

`ifdef DECODE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] br_cnt_q, br_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    br_cnt_d    = br_cnt_q;
    if (bus.stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (br_taken_v && !bus.stall && (br_cnt_q != 16'hFFFF)) br_cnt_d = br_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      br_cnt_q    <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.br_cnt    = br_cnt_q;
`endif
endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers (power of two, at least 2); AW = clog2(REG_NUM).
REQ-002 SHALL have parameter DATA_W, default 32, register and operand width (at least 32).
REQ-003 SHALL have parameter FWD_SRC, default 3, number of forwarding sources; SW = clog2(FWD_SRC+1).
REQ-004 SHALL have ports: clk in 1 (clock); reset in 1 (asynchronous, active-low).
REQ-005 SHALL have inputs: instr_f 32 (fetched instruction); pc_f 32 (fetch PC); stall 1 (hold IF/ID); flush 1 (bubble IF/ID).
REQ-006 SHALL have inputs: rf_we 1 (write enable); rf_wa AW (write address); rf_wd DATA_W (write data).
REQ-007 SHALL have inputs: fwd_data FWD_SRC*DATA_W (source k at bits [k*DATA_W +: DATA_W]); fwd_sel1 SW; fwd_sel2 SW.
REQ-008 SHALL have inputs: ext_op 1 (1 = sign-extend, 0 = zero-extend); cmp_op 3 (compare mode); npc_op 2 (next-PC mode).
REQ-009 SHALL have outputs: instr_d 32; pc_d 32; rd1 DATA_W; rd2 DATA_W; imm32 DATA_W; next_pc 32; br_taken 1.

Function
REQ-010 IF/ID register SHALL load instr_f/pc_f on the rising clk edge when stall=0 and flush=0.
REQ-011 stall=1 SHALL hold instr_d/pc_d; stall SHALL take priority over flush.
REQ-012 flush=1 with stall=0 SHALL load instr_d=0 and pc_d=pc_f.
REQ-013 Read addresses SHALL be rs=instr_d[25:21] and rt=instr_d[20:16], truncated or zero-padded to AW bits.
REQ-014 Register file SHALL write rf_wd to entry rf_wa on the rising edge when rf_we=1 and rf_wa!=0; entry 0 SHALL always read 0.
REQ-015 Reads SHALL be combinational; a read of an address being written this cycle (rf_we=1, nonzero address) SHALL return rf_wd.
REQ-016 rd1 SHALL be the RF value when fwd_sel1=0, fwd_data source fwd_sel1-1 when 1<=fwd_sel1<=FWD_SRC, and the RF value when out of range; rd2 SHALL follow the same rule with fwd_sel2.
REQ-017 imm32 SHALL be instr_d[15:0] extended to DATA_W per ext_op.
REQ-018 br_taken SHALL be decided on signed rd1/rd2 per cmp_op: 0 EQ, 1 NE, 2 LEZ(rd1), 3 GTZ(rd1), 4 LTZ(rd1), 5 GEZ(rd1); 6 and 7 SHALL give 0.
REQ-019 next_pc SHALL be computed per npc_op: 0 pc_f+4; 1 br_taken ? pc_d+4+(sext(imm16)<<2) : pc_f+4; 2 {pc_d[31:28], instr_d[25:0], 2'b00}; 3 rd1[31:0].
REQ-020 All PC arithmetic SHALL be modulo 2^32.
REQ-021 br_taken SHALL be forced to 0 when npc_op!=1.

Reset
REQ-022 reset=0 SHALL asynchronously set instr_d=0, pc_d=32'h0000_3000, all RF entries to 0, and counters to 0.
REQ-023 Deassertion of reset SHALL take effect at the next rising edge; a write pending while reset=0 SHALL be discarded.

Configuration
REQ-024 With DECODE_PERF_EN defined, SHALL add outputs stall_cnt 16 and br_cnt 16.
REQ-025 stall_cnt SHALL increment on each edge with stall=1; br_cnt SHALL increment on each edge with br_taken=1 and stall=0; both SHALL saturate at 16'hFFFF.
REQ-026 Without DECODE_PERF_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then one edge loading instr_f=32'h1000_0003, pc_f=32'h3004 -> instr_d=32'h1000_0003, pc_d=32'h3004; reset pulse -> pc_d=32'h3000 immediately.
REQ-028 Write reg 5=32'hDEAD_BEEF with instr_d rs=5 in the same cycle -> rd1=32'hDEAD_BEEF before the edge (bypass); write to reg 0 -> rd1=0 when rs=0.
REQ-029 fwd_sel1=2 with source 1=32'h1234 -> rd1=32'h1234; fwd_sel1=FWD_SRC+1 -> RF value.
REQ-030 pc_d=32'h3000, imm16=16'hFFFF, rd1=rd2, cmp_op=0, npc_op=1 -> next_pc=32'h3000, br_taken=1; with cmp_op=1 -> next_pc=pc_f+4.
REQ-031 stall=1 and flush=1 together for 2 cycles -> instr_d unchanged; then flush only -> instr_d=0; with DECODE_PERF_EN, stall_cnt=2.
